// File: rtl/game_state_tap_pkg.sv
// ============================================================================
// Module   : game_state_tap_pkg
// Purpose  : Default register map and event record layout for game_state_tap.
// Revision : 1.0
// ============================================================================
`default_nettype none

package game_state_tap_pkg;

    localparam logic [4:0] REG_NONE     = 5'd0;
    localparam logic [4:0] REG_LEVEL    = 5'd3;
    localparam logic [4:0] REG_SCREEN   = 5'd4;
    localparam logic [4:0] REG_GAMEOVER = 5'd6;

    // ch0=$r3, ch1=$r4, ch2=$r6, ch3 parked on $r0 (disabled)
    localparam logic [19:0] DEFAULT_CH_REGS = {REG_NONE, REG_GAMEOVER, REG_SCREEN, REG_LEVEL};

    // Event record for the default build (four channels, 32-bit data)
    typedef struct packed {
        logic [1:0]  ch;
        logic [31:0] data;
    } tap_evt_t;

endpackage

`default_nettype wire

// File: rtl/tap_event_fifo.sv
// ============================================================================
// Module   : tap_event_fifo
// Purpose  : Synchronous show-ahead FIFO with registered head, count and drop flag.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tap_event_fifo #(
    parameter int WIDTH = 34,
    parameter int DEPTH = 8,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    output logic             dropped,
    output logic             valid,
    input  logic             ready,
    output logic [WIDTH-1:0] rdata,
    output logic [CNT_W-1:0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    rd_next;
    logic             pop;
    logic             full;
    logic             accept;
    logic [CNT_W-1:0] remain;
    logic [CNT_W-1:0] count_next;

    assign pop        = valid && ready;
    assign full       = (count == CNT_W'(DEPTH));
    assign accept     = push && (!full || pop);
    assign dropped    = push && full && !pop;
    assign rd_next    = rd_ptr + AW'(pop);
    assign remain     = count - CNT_W'(pop);
    assign count_next = remain + CNT_W'(accept);

    always_ff @(posedge clock) begin
        if (accept) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            valid  <= 1'b0;
            rdata  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(accept);
            rd_ptr <= rd_next;
            count  <= count_next;
            valid  <= (count_next != '0);
            // Nothing left behind the pop: the incoming word becomes the head
            if (remain == '0) begin
                if (accept) begin
                    rdata <= wdata;
                end
            end else begin
                rdata <= mem[rd_next];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/game_state_tap.sv
// ============================================================================
// Module   : game_state_tap
// Purpose  : Regfile write-back snoop that shadows selected registers and
//            queues change events. Optional macro GAME_STATE_TAP_DEDUP_EN
//            suppresses events/pulses for unchanged values.
// Revision : 1.0
// ============================================================================
`default_nettype none

module game_state_tap
    import game_state_tap_pkg::*;
#(
    parameter int                  DATA_W     = 32,
    parameter int                  NUM_CH     = 4,
    parameter logic [5*NUM_CH-1:0] CH_REGS    = DEFAULT_CH_REGS,
    parameter int                  FIFO_DEPTH = 8,
    parameter int                  CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             ctrl_writeEnable,
    input  logic [4:0]                       ctrl_writeReg,
    input  logic [DATA_W-1:0]                data_writeReg,
    output logic [NUM_CH*DATA_W-1:0]         ch_value,
    output logic [NUM_CH-1:0]                ch_update,
    output logic                             evt_valid,
    input  logic                             evt_ready,
    output logic [CH_W-1:0]                  evt_ch,
    output logic [DATA_W-1:0]                evt_data,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  evt_count,
    output logic                             overflow,
    input  logic                             clr_overflow
);

    typedef struct packed {
        logic [CH_W-1:0]   ch;
        logic [DATA_W-1:0] data;
    } evt_t;

    logic [NUM_CH-1:0] hit;
    logic [NUM_CH-1:0] fire;
    logic [CH_W-1:0]   push_ch;
    logic              push;
    logic              dropped;
    evt_t              push_evt;
    evt_t              head_evt;

    always_comb begin
        hit  = '0;
        fire = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            hit[i] = ctrl_writeEnable && (ctrl_writeReg != 5'd0) &&
                     (ctrl_writeReg == CH_REGS[5*i +: 5]);
`ifdef GAME_STATE_TAP_DEDUP_EN
            fire[i] = hit[i] && (data_writeReg != ch_value[DATA_W*i +: DATA_W]);
`else
            fire[i] = hit[i];
`endif
        end
    end

    // Lowest firing channel wins the single push slot
    always_comb begin
        push_ch = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (fire[i]) begin
                push_ch = CH_W'(i);
            end
        end
    end

    assign push          = |fire;
    assign push_evt.ch   = push_ch;
    assign push_evt.data = data_writeReg;
    assign evt_ch        = head_evt.ch;
    assign evt_data      = head_evt.data;

    tap_event_fifo #(
        .WIDTH (CH_W + DATA_W),
        .DEPTH (FIFO_DEPTH),
        .CNT_W ($clog2(FIFO_DEPTH + 1))
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push    (push),
        .wdata   (push_evt),
        .dropped (dropped),
        .valid   (evt_valid),
        .ready   (evt_ready),
        .rdata   (head_evt),
        .count   (evt_count)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ch_value  <= '0;
            ch_update <= '0;
            overflow  <= 1'b0;
        end else begin
            ch_update <= fire;
            for (int i = 0; i < NUM_CH; i++) begin
                if (hit[i]) begin
                    ch_value[DATA_W*i +: DATA_W] <= data_writeReg;
                end
            end
            if (dropped) begin
                overflow <= 1'b1;
            end else if (clr_overflow) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_game_state_tap.sv
// ============================================================================
// Module   : tb_game_state_tap
// Purpose  : Self-checking bench for game_state_tap (vector table, directed
//            corner sequences, randomized traffic against a queue model).
// Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_game_state_tap;

    localparam int DATA_W = 32;
    localparam int NUM_CH = 4;
    localparam int DEPTH  = 8;
    localparam int CH_W   = 2;
    localparam int CNT_W  = 4;

    logic                     clock = 1'b0;
    logic                     reset = 1'b1;
    logic                     we    = 1'b0;
    logic [4:0]               wreg  = '0;
    logic [DATA_W-1:0]        wdata = '0;
    logic                     ready = 1'b0;
    logic                     clr   = 1'b0;
    logic [NUM_CH*DATA_W-1:0] ch_value;
    logic [NUM_CH-1:0]        ch_update;
    logic                     evt_valid;
    logic [CH_W-1:0]          evt_ch;
    logic [DATA_W-1:0]        evt_data;
    logic [CNT_W-1:0]         evt_count;
    logic                     overflow;

    always #5 clock = ~clock;

    game_state_tap dut (
        .clock            (clock),
        .reset            (reset),
        .ctrl_writeEnable (we),
        .ctrl_writeReg    (wreg),
        .data_writeReg    (wdata),
        .ch_value         (ch_value),
        .ch_update        (ch_update),
        .evt_valid        (evt_valid),
        .evt_ready        (ready),
        .evt_ch           (evt_ch),
        .evt_data         (evt_data),
        .evt_count        (evt_count),
        .overflow         (overflow),
        .clr_overflow     (clr)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: register map, shadows, and the event queue as a plain queue
    typedef struct {
        int                ch;
        logic [DATA_W-1:0] data;
    } mevt_t;

    int                ch_map [NUM_CH] = '{3, 4, 6, 0};
    logic [DATA_W-1:0] m_shadow [NUM_CH];
    logic [NUM_CH-1:0] m_upd;
    logic              m_ovf;
    mevt_t             m_q [$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) m_shadow[c] = '0;
        m_upd = '0;
        m_ovf = 1'b0;
        m_q.delete();
    endtask

    task automatic model_step(input logic i_we, input logic [4:0] i_reg,
                              input logic [DATA_W-1:0] i_d, input logic i_rdy, input logic i_clr);
        logic [NUM_CH-1:0] eff;
        bit                popped;
        bit                drop;
        int                first;
        mevt_t             e;
        eff    = '0;
        drop   = 0;
        first  = 0;
        popped = (m_q.size() > 0) && i_rdy;
        for (int c = 0; c < NUM_CH; c++) begin
            if (i_we && i_reg != 0 && int'(i_reg) == ch_map[c]) begin
`ifdef GAME_STATE_TAP_DEDUP_EN
                eff[c] = (i_d != m_shadow[c]);
`else
                eff[c] = 1'b1;
`endif
                m_shadow[c] = i_d;
            end
        end
        if (popped) void'(m_q.pop_front());
        if (eff != 0) begin
            for (int c = NUM_CH - 1; c >= 0; c--) if (eff[c]) first = c;
            if (m_q.size() < DEPTH) begin
                e.ch   = first;
                e.data = i_d;
                m_q.push_back(e);
            end else begin
                drop = 1;
            end
        end
        if (drop) m_ovf = 1'b1;
        else if (i_clr) m_ovf = 1'b0;
        m_upd = eff;
    endtask

    task automatic check_model();
        for (int c = 0; c < NUM_CH; c++)
            check("ch_value", ch_value[DATA_W*c +: DATA_W], m_shadow[c]);
        check("ch_update", ch_update, m_upd);
        check("evt_count", evt_count, m_q.size());
        check("evt_valid", evt_valid, m_q.size() > 0);
        check("overflow", overflow, m_ovf);
        if (m_q.size() > 0) begin
            check("evt_ch", evt_ch, m_q[0].ch);
            check("evt_data", evt_data, m_q[0].data);
        end
    endtask

    // Called at posedge+1; drives inputs, clocks once, updates model, returns at posedge+1
    task automatic step(input logic i_we, input logic [4:0] i_reg,
                        input logic [DATA_W-1:0] i_d, input logic i_rdy, input logic i_clr);
        we    = i_we;
        wreg  = i_reg;
        wdata = i_d;
        ready = i_rdy;
        clr   = i_clr;
        @(posedge clock);
        model_step(i_we, i_reg, i_d, i_rdy, i_clr);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " ch_value"}, ch_value, 0);
        check({tag, " ch_update"}, ch_update, 0);
        check({tag, " evt_valid"}, evt_valid, 0);
        check({tag, " evt_ch"}, evt_ch, 0);
        check({tag, " evt_data"}, evt_data, 0);
        check({tag, " evt_count"}, evt_count, 0);
        check({tag, " overflow"}, overflow, 0);
    endtask

    typedef struct {
        logic                     we;
        logic [4:0]               rg;
        logic [DATA_W-1:0]        d;
        logic                     rdy;
        logic [NUM_CH-1:0]        upd;
        int                       cnt;
        logic                     vld;
        logic [CH_W-1:0]          ch;
        logic [DATA_W-1:0]        dat;
        logic [NUM_CH*DATA_W-1:0] val;
    } vec_t;

    vec_t tbl [8];

    initial begin
        logic [NUM_CH*DATA_W-1:0] v1, v2, v3;
        int pulses;
        v1 = {32'h0, 32'h0, 32'h2, 32'h0};
        v2 = {32'h0, 32'hB, 32'h2, 32'h0};
        v3 = {32'h0, 32'hB, 32'h2, 32'h3};
        tbl[0] = '{1'b1, 5'd4, 32'h2,  1'b0, 4'b0010, 1, 1'b1, 2'd1, 32'h2, v1};
        tbl[1] = '{1'b1, 5'd0, 32'h55, 1'b0, 4'b0000, 1, 1'b1, 2'd1, 32'h2, v1};
        tbl[2] = '{1'b1, 5'd5, 32'h7,  1'b0, 4'b0000, 1, 1'b1, 2'd1, 32'h2, v1};
        tbl[3] = '{1'b0, 5'd3, 32'h9,  1'b0, 4'b0000, 1, 1'b1, 2'd1, 32'h2, v1};
        tbl[4] = '{1'b0, 5'd0, 32'h0,  1'b1, 4'b0000, 0, 1'b0, 2'd0, 32'h0, v1};
        tbl[5] = '{1'b1, 5'd6, 32'hB,  1'b1, 4'b0100, 1, 1'b1, 2'd2, 32'hB, v2};
        tbl[6] = '{1'b1, 5'd3, 32'h3,  1'b1, 4'b0001, 1, 1'b1, 2'd0, 32'h3, v3};
        tbl[7] = '{1'b0, 5'd0, 32'h0,  1'b1, 4'b0000, 0, 1'b0, 2'd0, 32'h0, v3};

        model_reset();
        repeat (3) @(posedge clock);
        #1;
        check_all_zero("reset");
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        check_model();

        for (int i = 0; i < 8; i++) begin
            step(tbl[i].we, tbl[i].rg, tbl[i].d, tbl[i].rdy, 1'b0);
            check("tbl ch_update", ch_update, tbl[i].upd);
            check("tbl evt_count", evt_count, tbl[i].cnt);
            check("tbl evt_valid", evt_valid, tbl[i].vld);
            check("tbl ch_value", ch_value, tbl[i].val);
            if (tbl[i].vld) begin
                check("tbl evt_ch", evt_ch, tbl[i].ch);
                check("tbl evt_data", evt_data, tbl[i].dat);
            end
        end

        // Overflow: nine writes into an eight-deep queue, then drain and clear
        for (int v = 1; v <= 9; v++) step(1'b1, 5'd3, DATA_W'(v), 1'b0, 1'b0);
        check("ovf evt_count", evt_count, 8);
        check("ovf overflow", overflow, 1);
        for (int v = 1; v <= 8; v++) begin
            check("drain evt_data", evt_data, v);
            step(1'b0, 5'd0, '0, 1'b1, 1'b0);
        end
        check("drain evt_valid", evt_valid, 0);
        check("drain overflow held", overflow, 1);
        step(1'b0, 5'd0, '0, 1'b0, 1'b1);
        check("clr overflow", overflow, 0);
        check_model();

        // Full queue: push while popping must be accepted
        for (int v = 20; v < 28; v++) step(1'b1, 5'd3, DATA_W'(v), 1'b0, 1'b0);
        check("full evt_count", evt_count, 8);
        step(1'b1, 5'd6, 32'hA, 1'b1, 1'b0);
        check("push+pop evt_count", evt_count, 8);
        check("push+pop overflow", overflow, 0);
        check_model();
        for (int k = 0; k < 8; k++) begin
            if (k == 7) begin
                check("last evt_data", evt_data, 32'hA);
                check("last evt_ch", evt_ch, 2);
            end else begin
                check("full drain evt_data", evt_data, 21 + k);
            end
            step(1'b0, 5'd0, '0, 1'b1, 1'b0);
        end
        check("full drain evt_valid", evt_valid, 0);

        // Asynchronous reset with entries queued
        for (int v = 1; v <= 3; v++) step(1'b1, 5'd4, DATA_W'(v), 1'b0, 1'b0);
        check("pre-reset evt_count", evt_count, 3);
        we = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check_all_zero("async reset");
        model_reset();
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        step(1'b1, 5'd3, 32'h33, 1'b0, 1'b0);
        check("post-reset evt_count", evt_count, 1);
        check_model();
        step(1'b0, 5'd0, '0, 1'b1, 1'b0);

        // Same value written twice to one channel
        pulses = 0;
        step(1'b1, 5'd3, 32'h5, 1'b0, 1'b0);
        if (ch_update[0]) pulses++;
        step(1'b1, 5'd3, 32'h5, 1'b0, 1'b0);
        if (ch_update[0]) pulses++;
`ifdef GAME_STATE_TAP_DEDUP_EN
        check("repeat pulses", pulses, 1);
        check("repeat evt_count", evt_count, 1);
`else
        check("repeat pulses", pulses, 2);
        check("repeat evt_count", evt_count, 2);
`endif
        check_model();

        // Randomized traffic; small data range so repeats occur
        for (int n = 0; n < 600; n++) begin
            step($urandom_range(0, 3) != 0,
                 5'($urandom_range(0, 7)),
                 DATA_W'($urandom_range(0, 3)),
                 (n < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
                 $urandom_range(0, 15) == 0);
            check_model();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
